hello_scroll_ctrl: RTL and testbench
====================================

# hello_scroll_ctrl

Sequencing controller for the HELLO scrolling display. It replaces the divided 1 s clock with a single-cycle step enable in the `clk_50MHz` domain and runs a start/pause/stop state machine. On every step it advances a scroll position through a fixed 16-character message and drives an eight-digit, active-low seven-segment bus. It sits between the board push-buttons/switches and the HEX display pins.

## Interface
Parameters:
- `TICK_DIV`, 25_000_000: base clock cycles per scroll step at speed 0.
- `MSG_LEN`, 16: message length in characters (fixed message, see Operation).
- `NUM_DIGITS`, 8: number of seven-segment digits driven.

Ports:
- `clk_50MHz`, input, 1: sole clock. The whole block is in this domain.
- `reset`, input, 1: synchronous, active-high reset.
- `start`, input, 1: level, sampled each cycle. Requests RUN.
- `stop`, input, 1: level, sampled each cycle. Requests pause; a second stop request clears the display.
- `dir`, input, 1: 0 = scroll left (pos increments), 1 = scroll right (pos decrements).
- `speed`, input, 2: step period = `TICK_DIV << speed` cycles.
- `seg_bus`, output, `NUM_DIGITS*7`: active-low segments {g..a}. Digit 0 occupies bits [6:0] and is the leftmost digit.
- `pos`, output, 4: current scroll position, 0..MSG_LEN-1.
- `step_pulse`, output, 1: one-cycle strobe on each scroll step.
- `busy`, output, 1: high in RUN.

## Operation
- The message is fixed: H,E,L,L,O followed by 11 BLANK. Index 0 is H.
- States:
  - IDLE → RUN on `start`. On this transition, clear `pos` and the counter.
  - RUN → HOLD on `stop`.
  - HOLD → RUN on `start`. Keep `pos` and the counter as they are.
  - HOLD → IDLE on `stop`.
- If `start` and `stop` are asserted in the same cycle, `stop` wins.
- Holding `stop` for several cycles in RUN goes RUN→HOLD in the first cycle and HOLD→IDLE in the second.
- Counter behaviour:
  - Increments only in RUN. Frozen in HOLD.
  - When counter ≥ `(TICK_DIV << speed) - 1` in RUN: counter clears to 0, `step_pulse` = 1, and `pos` updates on the same edge.
- Comparison rule: the comparison is ≥. A `speed` decrease that leaves the counter above the new terminal produces a step on the next RUN cycle.
- Position update:
  - `dir`=0: `pos` ← (pos+1) mod MSG_LEN, so 15→0.
  - `dir`=1: `pos` ← (pos−1) mod MSG_LEN, so 0→15.
  - `dir` is sampled at the step edge only.
- Display content:
  - In RUN and HOLD, digit k shows message[(pos+k) mod MSG_LEN].
  - In IDLE, every digit is blank (7'b111_1111).
- Counter width: `$clog2(TICK_DIV*8)` bits, unsigned. No overflow is possible because the counter clears at the terminal value.

## Timing
- Reset values: state IDLE, `pos`=0, counter=0, `step_pulse`=0, `busy`=0, `seg_bus` all ones.
- `reset` overrides every other input in the same cycle, including reset asserted mid-RUN.
- `busy` is registered and goes high on the edge that enters RUN.
- `seg_bus` is registered and lags its source by one cycle:
  - It reflects the new `pos` and state one edge after they change.
  - Blanking on entry to IDLE appears one cycle after the state change.
  - The frame at `pos`=0 appears one cycle after entry to RUN from IDLE.
- The first step after IDLE→RUN occurs `TICK_DIV << speed` RUN cycles after entry.
- After a resume from HOLD, the next step occurs once the remaining count elapses.

## Structure
- Package `hello_scroll_pkg` holds:
  - 3-bit character codes CH_BLANK=0, CH_H=1, CH_E=2, CH_L=3, CH_O=4.
  - The state enum IDLE/RUN/HOLD.
  - The message constant array.
- Sub-module `char_to_seg` is the combinational decoder from a 3-bit code to 7-bit active-low segments (H=0001001, E=0000110, L=1000111, O=1000000, BLANK=1111111). Instantiate it once per digit.

## Test plan
Run all scenarios with `TICK_DIV`=4.
- **Reset, then start, speed=0, dir=0:** `busy`=1 one cycle after start. `step_pulse` pulses every 4 cycles. `pos` goes 0,1,2… Digit 0 reads H then E; digit 4 reads O at pos 0.
- **Wrap-around:** with dir=0, run 16 steps → `pos` 15→0 and the frame at pos 0 repeats. With dir=1 starting from pos 0, the first step gives `pos`=15 and digit 1 shows H.
- **Pause and resume:** in RUN, with counter=2, assert stop for 1 cycle → HOLD, `pos` and counter frozen, display unchanged. Assert start → next step occurs 2 cycles later (counter 2→3).
- **stop twice:** RUN → HOLD → IDLE, with `seg_bus` all ones one cycle after IDLE. A following start restarts from `pos`=0. Simultaneous start+stop in RUN → HOLD.
- **Speed change:** speed=3 gives steps every 32 cycles. Switch to speed=0 with counter=20 → step on the next cycle, then every 4 cycles.
- **Reset mid-RUN:** assert reset with `pos`=7 → next edge has all outputs at their reset values. start and stop asserted during reset are ignored.

Source files
------------

// File: rtl/hello_scroll_pkg.sv
// Shared definitions for the HELLO scroll controller: character codes, FSM states and the message.
package hello_scroll_pkg;

  localparam logic [2:0] CH_BLANK = 3'd0;
  localparam logic [2:0] CH_H     = 3'd1;
  localparam logic [2:0] CH_E     = 3'd2;
  localparam logic [2:0] CH_L     = 3'd3;
  localparam logic [2:0] CH_O     = 3'd4;

  localparam int MSG_CHARS = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } scroll_state_t;

  localparam logic [2:0] MESSAGE [MSG_CHARS] = '{
    CH_H, CH_E, CH_L, CH_L, CH_O,
    CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK,
    CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK
  };

  // Index wraps so callers can pass pos + digit offset directly.
  function automatic logic [2:0] msg_char(input int idx);
    logic [3:0] idx4;
    idx4 = 4'(idx % MSG_CHARS);
    return MESSAGE[idx4];
  endfunction

endpackage

// File: rtl/hello_scroll_ctrl_char_to_seg.sv
// Combinational decoder from a 3-bit character code to active-low segments {g..a}.
module char_to_seg
  import hello_scroll_pkg::*;
(
  input  logic [2:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'b111_1111;
    case (code)
      CH_H:    seg = 7'b000_1001;
      CH_E:    seg = 7'b000_0110;
      CH_L:    seg = 7'b100_0111;
      CH_O:    seg = 7'b100_0000;
      default: seg = 7'b111_1111;
    endcase
  end

endmodule

// File: rtl/hello_scroll_ctrl.sv
// Start/pause/stop sequencer that scrolls a fixed message across an eight-digit
// seven-segment bus, stepping on a single-cycle enable derived from clk_50MHz.
module hello_scroll_ctrl
  import hello_scroll_pkg::*;
#(
  parameter int TICK_DIV   = 25_000_000,
  parameter int MSG_LEN    = 16,
  parameter int NUM_DIGITS = 8
) (
  input  logic                    clk_50MHz,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    dir,
  input  logic [1:0]              speed,
  output logic [NUM_DIGITS*7-1:0] seg_bus,
  output logic [3:0]              pos,
  output logic                    step_pulse,
  output logic                    busy
);

  localparam int CNT_W = $clog2(TICK_DIV * 8);

  scroll_state_t           state_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic [3:0]              pos_reg;
  logic                    step_reg;
  logic                    busy_reg;
  logic [NUM_DIGITS*7-1:0] seg_reg;
  logic [NUM_DIGITS*7-1:0] seg_next;

  logic [CNT_W:0]          term_next;
  logic                    at_term_next;
  logic [3:0]              pos_inc_next;
  logic [3:0]              pos_dec_next;

  // One extra bit so TICK_DIV << 3 itself is representable before the -1.
  always_comb begin
    term_next    = ((CNT_W+1)'(TICK_DIV) << speed) - (CNT_W+1)'(1);
    at_term_next = ({1'b0, cnt_reg} >= term_next);
    pos_inc_next = (pos_reg == 4'(MSG_LEN - 1)) ? 4'd0 : pos_reg + 4'd1;
    pos_dec_next = (pos_reg == 4'd0) ? 4'(MSG_LEN - 1) : pos_reg - 4'd1;
  end

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      pos_reg   <= 4'd0;
      step_reg  <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      step_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start && !stop) begin
            state_reg <= RUN;
            cnt_reg   <= '0;
            pos_reg   <= 4'd0;
            busy_reg  <= 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            state_reg <= HOLD;
            busy_reg  <= 1'b0;
          end else if (at_term_next) begin
            cnt_reg  <= '0;
            step_reg <= 1'b1;
            pos_reg  <= dir ? pos_dec_next : pos_inc_next;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        HOLD: begin
          // Counter and position stay frozen so a resume finishes the partial step.
          if (stop) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else if (start) begin
            state_reg <= RUN;
            busy_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic [2:0] code_next;
      assign code_next = (state_reg == IDLE) ? CH_BLANK : msg_char(int'(pos_reg) + gi);
      char_to_seg u_char_to_seg (
        .code (code_next),
        .seg  (seg_next[gi*7 +: 7])
      );
    end
  endgenerate

  // Display frame is registered, so it trails state/pos by one edge.
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      seg_reg <= '1;
    end else begin
      seg_reg <= seg_next;
    end
  end

  assign seg_bus    = seg_reg;
  assign pos        = pos_reg;
  assign step_pulse = step_reg;
  assign busy       = busy_reg;

endmodule

// File: tb/tb_hello_scroll_ctrl.sv
// Scoreboard bench: stimulus runs a behavioural model and queues expected outputs; a monitor compares every cycle.
module tb_hello_scroll_ctrl;

  localparam int TD = 4;
  localparam int ND = 8;
  localparam int ML = 16;

  logic          clk_50MHz = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          dir = 1'b0;
  logic [1:0]    speed = 2'd0;
  logic [ND*7-1:0] seg_bus;
  logic [3:0]    pos;
  logic          step_pulse;
  logic          busy;

  hello_scroll_ctrl #(
    .TICK_DIV   (TD),
    .MSG_LEN    (ML),
    .NUM_DIGITS (ND)
  ) dut (
    .clk_50MHz  (clk_50MHz),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .dir        (dir),
    .speed      (speed),
    .seg_bus    (seg_bus),
    .pos        (pos),
    .step_pulse (step_pulse),
    .busy       (busy)
  );

  always #5 clk_50MHz = ~clk_50MHz;

  typedef struct {
    logic [ND*7-1:0] seg;
    logic [3:0]      pos;
    logic            step;
    logic            busy;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   steps_seen = 0;
  bit   stim_done = 0;

  // Model state: mode 0 = idle, 1 = running, 2 = paused.
  int m_mode = 0;
  int m_pos = 0;
  int m_elapsed = 0;

  function automatic byte char_at(input int i);
    case (i)
      0: return "H";
      1: return "E";
      2: return "L";
      3: return "L";
      4: return "O";
      default: return " ";
    endcase
  endfunction

  function automatic logic [6:0] glyph(input byte c);
    case (c)
      "H": return 7'h09;
      "E": return 7'h06;
      "L": return 7'h47;
      "O": return 7'h40;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [ND*7-1:0] frame(input int mode, input int p);
    logic [ND*7-1:0] r;
    r = '1;
    if (mode != 0)
      for (int k = 0; k < ND; k++) r[k*7 +: 7] = glyph(char_at((p + k) % ML));
    return r;
  endfunction

  task automatic tick(input logic r, input logic s, input logic t, input logic d, input logic [1:0] sp);
    exp_t e;
    int period;
    @(negedge clk_50MHz);
    reset = r; start = s; stop = t; dir = d; speed = sp;
    period = TD * (1 << sp);
    e.step = 1'b0;
    if (r) begin
      m_mode = 0; m_pos = 0; m_elapsed = 0;
      e.seg = '1;
    end else begin
      e.seg = frame(m_mode, m_pos);
      if (m_mode == 0) begin
        if (s && !t) begin m_mode = 1; m_pos = 0; m_elapsed = 0; end
      end else if (m_mode == 1) begin
        if (t) m_mode = 2;
        else if (m_elapsed + 1 >= period) begin
          m_elapsed = 0;
          e.step = 1'b1;
          m_pos = d ? (m_pos + ML - 1) % ML : (m_pos + 1) % ML;
        end else m_elapsed++;
      end else begin
        if (t) m_mode = 0;
        else if (s) m_mode = 1;
      end
    end
    e.pos  = 4'(m_pos);
    e.busy = (m_mode == 1);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n, input logic d, input logic [1:0] sp);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, d, sp);
  endtask

  // Advance until the model reaches the wanted counter (use_pos=0) or position (use_pos=1).
  task automatic run_until(input bit use_pos, input int val, input logic d, input logic [1:0] sp);
    int i;
    for (i = 0; i < 200; i++) begin
      if (m_mode == 1 && (use_pos ? m_pos : m_elapsed) == val) break;
      tick(1'b0, 1'b0, 1'b0, d, sp);
    end
    total++;
    if (i == 200) begin
      bad++;
      $display("FAIL run_until actual=timeout required=%0d", val);
    end
  endtask

  task automatic check(input string name, input logic [ND*7-1:0] act, input logic [ND*7-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at %0t actual=%h required=%h", name, $time, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk_50MHz);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("seg_bus", seg_bus, e.seg);
        check("pos", {52'd0, pos}, {52'd0, e.pos});
        check("step_pulse", {55'd0, step_pulse}, {55'd0, e.step});
        check("busy", {55'd0, busy}, {55'd0, e.busy});
        if (e.step) begin
          steps_seen++;
          $display("step %0d: pos=%0d digit0=%h digit1=%h", steps_seen, pos, seg_bus[6:0], seg_bus[13:7]);
        end
      end
    end
  end

  initial begin : stimulus
    logic d;
    logic [1:0] sp;
    // Reset with start/stop held: both must be ignored.
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b1, 1'b0, 2'd0);
    idle(2, 1'b0, 2'd0);
    // Start at speed 0, scroll left past the wrap point.
    tick(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    idle(72, 1'b0, 2'd0);
    // Scroll right across pos 0.
    run_until(1'b1, 0, 1'b0, 2'd0);
    idle(12, 1'b1, 2'd0);
    // Pause with counter at 2, then resume.
    run_until(1'b0, 2, 1'b0, 2'd0);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    idle(5, 1'b0, 2'd0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    idle(10, 1'b0, 2'd0);
    // Stop held two cycles: run -> hold -> idle, then restart.
    tick(1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    idle(3, 1'b0, 2'd0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    idle(9, 1'b0, 2'd0);
    // Simultaneous start and stop in run.
    tick(1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
    idle(3, 1'b0, 2'd0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    // Slow speed, then drop speed with the counter above the new terminal.
    idle(70, 1'b0, 2'd3);
    run_until(1'b0, 20, 1'b0, 2'd3);
    idle(12, 1'b0, 2'd0);
    // Reset mid-run at pos 7 with start/stop asserted.
    run_until(1'b1, 7, 1'b0, 2'd0);
    tick(1'b1, 1'b1, 1'b1, 1'b0, 2'd0);
    tick(1'b1, 1'b1, 1'b1, 1'b0, 2'd0);
    idle(3, 1'b0, 2'd0);
    // Randomised control traffic.
    d = 1'b0;
    sp = 2'd0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 49) == 0) d = ~d;
      if ($urandom_range(0, 99) == 0) sp = 2'($urandom_range(0, 3));
      tick(($urandom_range(0, 299) == 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 29) == 0), d, sp);
    end
    idle(2, 1'b0, 2'd0);
    stim_done = 1;
  end

  initial begin : finisher
    int waited;
    wait (stim_done);
    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge clk_50MHz);
      waited++;
    end
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
